// File: rtl/acs_stage2.sv
// Add-compare-select stage of a rate-1/2, K=3 (7,5) Viterbi decoder.
// Keeps four modulo path metrics and emits per-state survivor bits plus the best state.
module acs_stage2 #(
  parameter int PM_W     = 12,
  parameter int INIT_PEN = 256,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       d1_in,
  input  logic [7:0]       d2_in,
  input  logic [7:0]       d3_in,
  input  logic [7:0]       d4_in,
  output logic             out_valid,
  output logic [3:0]       dec_out,
  output logic [PM_W-1:0]  pm0_out,
  output logic [PM_W-1:0]  pm1_out,
  output logic [PM_W-1:0]  pm2_out,
  output logic [PM_W-1:0]  pm3_out,
  output logic [1:0]       best_state,
  output logic [CNT_W-1:0] step_cnt
);

  localparam logic [0:0]      IDLE    = 1'b0;
  localparam logic [0:0]      RUN     = 1'b1;
  localparam logic [PM_W-1:0] PM_ZERO = {PM_W{1'b0}};
  localparam logic [PM_W-1:0] INIT_M  = PM_W'(-INIT_PEN);

  function automatic logic [PM_W-1:0] sm_to_pm(input logic [7:0] d);
    logic [8:0] mag9;
    logic [8:0] v9;
    mag9 = {2'b00, d[6:0]};
    if (d[7]) v9 = 9'd0 - mag9;
    else      v9 = mag9;
    return {{(PM_W-9){v9[8]}}, v9};
  endfunction

  // Modulo compare: a beats b when a-b, read in PM_W bits, is positive and nonzero.
  function automatic logic pm_gt(input logic [PM_W-1:0] a, input logic [PM_W-1:0] b);
    logic [PM_W-1:0] diff;
    diff = a - b;
    return (diff[PM_W-1] == 1'b0) && (diff != PM_ZERO);
  endfunction

  logic [0:0]       state_r;
  logic [PM_W-1:0]  pm_r    [4];
  logic [3:0]       dec_r;
  logic [1:0]       best_r;
  logic             out_valid_r;
  logic [CNT_W-1:0] cnt_r;

  logic [PM_W-1:0]  base_s  [4];
  logic [PM_W-1:0]  cand0_s [4];
  logic [PM_W-1:0]  cand1_s [4];
  logic [PM_W-1:0]  new_s   [4];
  logic [PM_W-1:0]  bm00_s, bm11_s, bm01_s, bm10_s;
  logic [3:0]       dec_s;
  logic [1:0]       best_s;
  logic [CNT_W-1:0] cnt_s;

  // Branch metric conversion, butterfly ACS, argmax and counter next-state.
  always_comb begin
    if (start || (state_r == IDLE)) begin
      base_s[0] = PM_ZERO;
      base_s[1] = INIT_M;
      base_s[2] = INIT_M;
      base_s[3] = INIT_M;
    end else begin
      for (int i = 0; i < 4; i++) base_s[i] = pm_r[i];
    end

    bm00_s = sm_to_pm(d1_in);
    bm11_s = sm_to_pm(d2_in);
    bm01_s = sm_to_pm(d3_in);
    bm10_s = sm_to_pm(d4_in);

    // Index = new state; cand0 comes from predecessor {n[0],0}, cand1 from {n[0],1}.
    cand0_s[0] = base_s[0] + bm00_s;
    cand1_s[0] = base_s[1] + bm11_s;
    cand0_s[2] = base_s[0] + bm11_s;
    cand1_s[2] = base_s[1] + bm00_s;
    cand0_s[1] = base_s[2] + bm10_s;
    cand1_s[1] = base_s[3] + bm01_s;
    cand0_s[3] = base_s[2] + bm01_s;
    cand1_s[3] = base_s[3] + bm10_s;

    for (int i = 0; i < 4; i++) begin
      dec_s[i] = pm_gt(cand1_s[i], cand0_s[i]);
      new_s[i] = dec_s[i] ? cand1_s[i] : cand0_s[i];
    end

    best_s = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (pm_gt(new_s[i], new_s[best_s])) best_s = 2'(i);
      else                                best_s = best_s;
    end

    if (start) begin
      cnt_s = in_valid ? {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b0}};
    end else if (in_valid && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_s = cnt_r;
    end
  end

  // Registered metrics, decisions, FSM and step counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      pm_r[0]     <= PM_ZERO;
      pm_r[1]     <= INIT_M;
      pm_r[2]     <= INIT_M;
      pm_r[3]     <= INIT_M;
      dec_r       <= 4'b0000;
      best_r      <= 2'd0;
      out_valid_r <= 1'b0;
      cnt_r       <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE:    state_r <= (start || in_valid) ? RUN : IDLE;
        RUN:     state_r <= RUN;
        default: state_r <= IDLE;
      endcase
      out_valid_r <= in_valid;
      cnt_r       <= cnt_s;
      if (in_valid) begin
        for (int i = 0; i < 4; i++) pm_r[i] <= new_s[i];
        dec_r  <= dec_s;
        best_r <= best_s;
      end else if (start) begin
        for (int i = 0; i < 4; i++) pm_r[i] <= base_s[i];
        dec_r  <= 4'b0000;
        best_r <= 2'd0;
      end else begin
        for (int i = 0; i < 4; i++) pm_r[i] <= pm_r[i];
        dec_r  <= dec_r;
        best_r <= best_r;
      end
    end
  end

  assign out_valid  = out_valid_r;
  assign dec_out    = dec_r;
  assign pm0_out    = pm_r[0];
  assign pm1_out    = pm_r[1];
  assign pm2_out    = pm_r[2];
  assign pm3_out    = pm_r[3];
  assign best_state = best_r;
  assign step_cnt   = cnt_r;

endmodule

// File: tb/tb_acs_stage2.sv
// Directed bench for acs_stage2: hand-computed metrics, decisions and best state.
module tb_acs_stage2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  d1_in, d2_in, d3_in, d4_in;
  logic        out_valid;
  logic [3:0]  dec_out;
  logic [11:0] pm0_out, pm1_out, pm2_out, pm3_out;
  logic [1:0]  best_state;
  logic [15:0] step_cnt;

  int checks = 0;
  int errors = 0;

  acs_stage2 dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .d1_in(d1_in), .d2_in(d2_in), .d3_in(d3_in), .d4_in(d4_in),
    .out_valid(out_valid), .dec_out(dec_out),
    .pm0_out(pm0_out), .pm1_out(pm1_out), .pm2_out(pm2_out), .pm3_out(pm3_out),
    .best_state(best_state), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [7:0] d, input logic v, input logic s);
    d1_in = a; d2_in = b; d3_in = c; d4_in = d; in_valid = v; start = s;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    tick; tick;
    rst = 1'b0;
    tick;
    checks++;
    if ({pm0_out, pm1_out, pm2_out, pm3_out} !== {12'h000, 12'hF00, 12'hF00, 12'hF00}) begin
      errors++;
      $display("FAIL reset_pm got %h %h %h %h want 000 f00 f00 f00", pm0_out, pm1_out, pm2_out, pm3_out);
    end
    checks++;
    if ({out_valid, dec_out, best_state, step_cnt} !== {1'b0, 4'b0000, 2'd0, 16'd0}) begin
      errors++;
      $display("FAIL reset_ctl got v=%b dec=%b best=%0d cnt=%0d want 0 0000 0 0", out_valid, dec_out, best_state, step_cnt);
    end
  endtask

  task automatic test_first_symbol;
    drive(8'h20, 8'hA0, 8'h00, 8'h00, 1'b1, 1'b1);
    tick;
    drive(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    checks++;
    if ({pm0_out, pm1_out, pm2_out, pm3_out} !== {12'(32), 12'(-256), 12'(-32), 12'(-256)}) begin
      errors++;
      $display("FAIL first_pm got %h %h %h %h want 020 f00 fe0 f00", pm0_out, pm1_out, pm2_out, pm3_out);
    end
    checks++;
    if ({out_valid, dec_out, best_state, step_cnt} !== {1'b1, 4'b0000, 2'd0, 16'd1}) begin
      errors++;
      $display("FAIL first_ctl got v=%b dec=%b best=%0d cnt=%0d want 1 0000 0 1", out_valid, dec_out, best_state, step_cnt);
    end
  endtask

  task automatic test_zero_stream;
    int bad = 0;
    for (int k = 1; k <= 100; k++) begin
      drive(8'h20, 8'hA0, 8'h00, 8'h00, 1'b1, (k == 1));
      tick;
      checks++;
      if ({out_valid, best_state, dec_out, pm0_out} !== {1'b1, 2'd0, 4'b0000, 12'(32 * k)}) begin
        errors++;
        bad++;
        if (bad < 5) $display("FAIL zero_stream step %0d got v=%b best=%0d dec=%b pm0=%h want 1 0 0000 %h",
                              k, out_valid, best_state, dec_out, pm0_out, 12'(32 * k));
      end
    end
    // Idle cycle: everything holds, only out_valid drops.
    drive(8'h20, 8'hA0, 8'h00, 8'h00, 1'b0, 1'b0);
    tick;
    checks++;
    if ({out_valid, pm0_out, best_state, step_cnt} !== {1'b0, 12'(3200), 2'd0, 16'd100}) begin
      errors++;
      $display("FAIL hold got v=%b pm0=%h best=%0d cnt=%0d want 0 c80 0 100", out_valid, pm0_out, best_state, step_cnt);
    end
  endtask

  task automatic test_encoded;
    // Input bits 1,0,1,1,0 encode to 11,10,00,01,01.
    logic [7:0] t1 [5] = '{8'hA0, 8'h00, 8'h20, 8'h00, 8'h00};
    logic [7:0] t2 [5] = '{8'h20, 8'h00, 8'hA0, 8'h00, 8'h00};
    logic [7:0] t3 [5] = '{8'h00, 8'hA0, 8'h00, 8'h20, 8'h20};
    logic [7:0] t4 [5] = '{8'h00, 8'h20, 8'h00, 8'hA0, 8'hA0};
    int e0 [5] = '{-32, -32, 32, 32, 64};
    int e1 [5] = '{-256, 64, 0, 64, 160};
    int e2 [5] = '{32, -32, 96, 32, 64};
    int e3 [5] = '{-256, 0, 0, 128, 96};
    logic [3:0] ed [5] = '{4'h0, 4'h0, 4'hF, 4'h0, 4'hF};
    logic [1:0] eb [5] = '{2'd2, 2'd1, 2'd2, 2'd3, 2'd1};
    logic       ubits [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0] seen [5];
    logic [1:0] st;
    for (int i = 0; i < 5; i++) begin
      drive(t1[i], t2[i], t3[i], t4[i], 1'b1, (i == 0));
      tick;
      seen[i] = dec_out;
      checks++;
      if ({pm0_out, pm1_out, pm2_out, pm3_out} !== {12'(e0[i]), 12'(e1[i]), 12'(e2[i]), 12'(e3[i])}) begin
        errors++;
        $display("FAIL encoded_pm step %0d got %h %h %h %h want %h %h %h %h", i, pm0_out, pm1_out, pm2_out, pm3_out,
                 12'(e0[i]), 12'(e1[i]), 12'(e2[i]), 12'(e3[i]));
      end
      checks++;
      if ({dec_out, best_state} !== {ed[i], eb[i]}) begin
        errors++;
        $display("FAIL encoded_dec step %0d got dec=%b best=%0d want dec=%b best=%0d", i, dec_out, best_state, ed[i], eb[i]);
      end
    end
    drive(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    checks++;
    if (step_cnt !== 16'd5) begin
      errors++;
      $display("FAIL encoded_cnt got %0d want 5", step_cnt);
    end
    st = best_state;
    for (int i = 4; i >= 0; i--) begin
      checks++;
      if (st[1] !== ubits[i]) begin
        errors++;
        $display("FAIL traceback bit %0d got %b want %b", i, st[1], ubits[i]);
      end
      st = {st[0], seen[i][st]};
    end
  endtask

  task automatic test_tie;
    int e2 [3] = '{0, 0, 0};
    int e1 [3] = '{-256, 0, 0};
    int e3 [3] = '{-256, 0, 0};
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(8'h80, 8'h80, 8'h80, 8'h80, 1'b1, 1'b0);
      tick;
      checks++;
      if ({pm0_out, pm1_out, pm2_out, pm3_out, dec_out, best_state} !==
          {12'h000, 12'(e1[i]), 12'(e2[i]), 12'(e3[i]), 4'b0000, 2'd0}) begin
        errors++;
        $display("FAIL tie step %0d got %h %h %h %h dec=%b best=%0d want 000 %h %h %h 0000 0", i, pm0_out, pm1_out,
                 pm2_out, pm3_out, dec_out, best_state, 12'(e1[i]), 12'(e2[i]), 12'(e3[i]));
      end
    end
    drive(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_wrap_and_rst;
    int bad = 0;
    for (int k = 1; k <= 2000; k++) begin
      drive(8'h7F, 8'hFF, 8'h00, 8'h00, 1'b1, (k == 1));
      tick;
      checks++;
      if ({best_state, dec_out, pm0_out} !== {2'd0, 4'b0000, 12'(127 * k)}) begin
        errors++;
        bad++;
        if (bad < 5) $display("FAIL wrap step %0d got best=%0d dec=%b pm0=%h want 0 0000 %h",
                              k, best_state, dec_out, pm0_out, 12'(127 * k));
      end
    end
    checks++;
    if (step_cnt !== 16'd2000) begin
      errors++;
      $display("FAIL wrap_cnt got %0d want 2000", step_cnt);
    end
    // Async reset mid-cycle with a symbol still presented.
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({pm0_out, pm1_out, pm2_out, pm3_out, out_valid, dec_out, best_state, step_cnt} !==
        {12'h000, 12'hF00, 12'hF00, 12'hF00, 1'b0, 4'b0000, 2'd0, 16'd0}) begin
      errors++;
      $display("FAIL rst_mid got %h %h %h %h v=%b dec=%b best=%0d cnt=%0d", pm0_out, pm1_out, pm2_out, pm3_out,
               out_valid, dec_out, best_state, step_cnt);
    end
    tick;
    drive(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    tick;
    checks++;
    if ({out_valid, step_cnt, pm0_out} !== {1'b0, 16'd0, 12'h000}) begin
      errors++;
      $display("FAIL rst_after got v=%b cnt=%0d pm0=%h want 0 0 000", out_valid, step_cnt, pm0_out);
    end
  endtask

  task automatic test_start_only;
    drive(8'h20, 8'hA0, 8'h00, 8'h00, 1'b1, 1'b1);
    tick;
    drive(8'h00, 8'h00, 8'hA0, 8'h20, 1'b1, 1'b0);
    tick;
    drive(8'h20, 8'hA0, 8'h00, 8'h00, 1'b1, 1'b0);
    tick;
    drive(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    tick;
    drive(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    checks++;
    if ({pm0_out, pm1_out, pm2_out, pm3_out, out_valid, dec_out, best_state, step_cnt} !==
        {12'h000, 12'hF00, 12'hF00, 12'hF00, 1'b0, 4'b0000, 2'd0, 16'd0}) begin
      errors++;
      $display("FAIL start_only got %h %h %h %h v=%b dec=%b best=%0d cnt=%0d", pm0_out, pm1_out, pm2_out, pm3_out,
               out_valid, dec_out, best_state, step_cnt);
    end
  endtask

  initial begin
    test_reset;
    test_first_symbol;
    test_zero_stream;
    test_encoded;
    test_tie;
    test_wrap_and_rst;
    test_start_only;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
